iecdrv_sd_arbiter: RTL and testbench

Round-robin scheduler that shares the single host SD block channel (lba/blk_cnt/rd/wr/ack) between up to `NDRIVES` IEC drive instances, each of which issues whole-track read/write requests. It sits between the per-drive track loaders and the top-level SD interface. It latches the winning drive's request, drives the shared channel and routes the acknowledge and write-data back to the winner. The block is clocked in the `clk_sys` domain. The drives' request lines are already synchronised to that domain.

---
 rtl/iecdrv_sd_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_iecdrv_sd_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block channel between up to four IEC drives.
// Optional request watchdog enabled by defining SDARB_TIMEOUT_EN.
module iecdrv_sd_arbiter #(
    parameter int unsigned NDRIVES        = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NDRIVES-1:0]      req_rd,
    input  logic [NDRIVES-1:0]      req_wr,
    input  logic [32*NDRIVES-1:0]   req_lba,
    input  logic [6*NDRIVES-1:0]    req_blk_cnt,
    input  logic [8*NDRIVES-1:0]    req_buff_din,
    output logic [NDRIVES-1:0]      req_ack,
    output logic [31:0]             sd_lba,
    output logic [5:0]              sd_blk_cnt,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    output logic [7:0]              sd_buff_din,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic [NDRIVES-1:0]      timeout_err
);

    if (NDRIVES < 1 || NDRIVES > 4) begin : g_bad_ndrives
        $error("iecdrv_sd_arbiter: NDRIVES must be in 1..4");
    end
    if (TIMEOUT_CYCLES == 24'd0) begin : g_bad_timeout
        $error("iecdrv_sd_arbiter: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  last, last_nxt;
    logic [1:0]  grant_nxt;
    logic [31:0] lba_nxt;
    logic [5:0]  blk_nxt;
    logic        rd_nxt, wr_nxt;

    logic [3:0]  pend4;
    logic [1:0]  idx;
    logic [1:0]  pick;
    logic        found;
    logic [31:0] pick_lba;
    logic [5:0]  pick_blk;
    logic        pick_wr;
    logic        grant_pend;

`ifdef SDARB_TIMEOUT_EN
    logic [23:0]        cnt, cnt_nxt;
    logic [NDRIVES-1:0] tmo_q, tmo_nxt;
`endif

    // Round-robin scan starting just after the last served drive.
    always_comb begin
        pend4 = '0;
        pend4[NDRIVES-1:0] = req_rd | req_wr;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NDRIVES; k++) begin
            idx = 2'((32'(last) + k) % NDRIVES);
            if (!found && pend4[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_lba    = '0;
        pick_blk    = '0;
        pick_wr     = 1'b0;
        grant_pend  = 1'b0;
        sd_buff_din = '0;
        req_ack     = '0;
        for (int unsigned i = 0; i < NDRIVES; i++) begin
            if (pick == 2'(i)) begin
                pick_lba = req_lba[32*i +: 32];
                pick_blk = req_blk_cnt[6*i +: 6];
                pick_wr  = req_wr[i];
            end
            if (grant == 2'(i)) begin
                grant_pend  = req_rd[i] | req_wr[i];
                sd_buff_din = req_buff_din[8*i +: 8];
                req_ack[i]  = (state == XFER) && sd_ack;
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant;
        lba_nxt   = sd_lba;
        blk_nxt   = sd_blk_cnt;
        rd_nxt    = sd_rd;
        wr_nxt    = sd_wr;
`ifdef SDARB_TIMEOUT_EN
        cnt_nxt   = cnt;
        tmo_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    lba_nxt   = pick_lba;
                    blk_nxt   = pick_blk;
                    wr_nxt    = pick_wr;
                    rd_nxt    = !pick_wr;
                    state_nxt = REQ;
`ifdef SDARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            REQ: begin
`ifdef SDARB_TIMEOUT_EN
                cnt_nxt = cnt + 24'd1;
`endif
                // Host ack takes priority over a same-cycle cancel.
                if (sd_ack) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = XFER;
                end else if (!grant_pend) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
`ifdef SDARB_TIMEOUT_EN
                else if (cnt == TIMEOUT_CYCLES - 24'd1) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    last_nxt  = grant;
                    state_nxt = IDLE;
                    for (int unsigned i = 0; i < NDRIVES; i++) begin
                        if (grant == 2'(i)) tmo_nxt[i] = 1'b1;
                    end
                end
`endif
            end
            XFER: begin
                if (!sd_ack) state_nxt = DONE;
            end
            DONE: begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= 2'(NDRIVES - 1);
            grant      <= '0;
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
`ifdef SDARB_TIMEOUT_EN
            cnt        <= '0;
            tmo_q      <= '0;
`endif
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            grant      <= grant_nxt;
            sd_lba     <= lba_nxt;
            sd_blk_cnt <= blk_nxt;
            sd_rd      <= rd_nxt;
            sd_wr      <= wr_nxt;
`ifdef SDARB_TIMEOUT_EN
            cnt        <= cnt_nxt;
            tmo_q      <= tmo_nxt;
`endif
        end
    end

`ifdef SDARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Directed self-checking bench for iecdrv_sd_arbiter (4 drives, 16-cycle watchdog limit).
module tb_iecdrv_sd_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_rd, req_wr;
    logic [127:0] req_lba;
    logic [23:0]  req_blk_cnt;
    logic [31:0]  req_buff_din;
    logic [3:0]   req_ack;
    logic [31:0]  sd_lba;
    logic [5:0]   sd_blk_cnt;
    logic         sd_rd, sd_wr, sd_ack;
    logic [7:0]   sd_buff_din;
    logic [1:0]   grant;
    logic         busy;
    logic [3:0]   timeout_err;

    int nchecks = 0;
    int nerrors = 0;

    iecdrv_sd_arbiter #(.NDRIVES(4), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
        .req_blk_cnt(req_blk_cnt), .req_buff_din(req_buff_din),
        .req_ack(req_ack), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_din(sd_buff_din), .grant(grant), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acks, waits, zeros, bad;
        reset_n = 1'b0; sd_ack = 1'b0;
        req_rd = '0; req_wr = '0; req_lba = '0; req_blk_cnt = '0;
        req_buff_din = 32'h44_A5_22_11;
        step(); step();
        check("rst_rd", sd_rd, 0);
        check("rst_wr", sd_wr, 0);
        check("rst_lba", sd_lba, 0);
        check("rst_blk", sd_blk_cnt, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", req_ack, 0);
        check("rst_tmo", timeout_err, 0);
        reset_n = 1'b1;
        step();

        // Single read from drive 1
        req_lba[32*1 +: 32] = 32'h120;
        req_blk_cnt[6*1 +: 6] = 6'h0B;
        req_rd[1] = 1'b1;
        step();
        check("rd_strobe", sd_rd, 1);
        check("rd_wr_low", sd_wr, 0);
        check("rd_lba", sd_lba, 32'h120);
        check("rd_blk", sd_blk_cnt, 6'h0B);
        check("rd_grant", grant, 1);
        check("rd_buff", sd_buff_din, 8'h22);
        sd_ack = 1'b1; #1;
        check("rd_ack_in_req", req_ack, 0);
        step();
        check("rd_strobe_drop", sd_rd, 0);
        req_rd[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_ack == 4'b0010) acks++;
            if (i != 99) step();
        end
        check("rd_ack_cycles", acks, 100);
        sd_ack = 1'b0; #1;
        check("rd_ack_zero_lat", req_ack, 0);
        step();
        check("rd_busy_done", busy, 1);
        step();
        check("rd_busy_idle", busy, 0);

        // Write priority and data routing on drive 2
        req_rd[2] = 1'b1; req_wr[2] = 1'b1;
        step();
        check("wr_grant", grant, 2);
        check("wr_strobe", sd_wr, 1);
        check("wr_rd_low", sd_rd, 0);
        check("wr_buff_req", sd_buff_din, 8'hA5);
        sd_ack = 1'b1;
        step();
        req_rd[2] = 1'b0; req_wr[2] = 1'b0; #1;
        check("wr_buff_xfer", sd_buff_din, 8'hA5);
        check("wr_ack", req_ack, 4'b0100);
        check("wr_strobe_drop", sd_wr, 0);
        sd_ack = 1'b0;
        step(); step();

        // Reset while in XFER with drive 3 (last = 2)
        req_rd[3] = 1'b1;
        step();
        check("rx_grant", grant, 3);
        sd_ack = 1'b1;
        step();
        check("rx_ack", req_ack, 4'b1000);
        reset_n = 1'b0;
        step();
        check("rx_busy", busy, 0);
        check("rx_ack_clr", req_ack, 0);
        check("rx_rd", sd_rd, 0);
        check("rx_wr", sd_wr, 0);
        check("rx_grant0", grant, 0);
        reset_n = 1'b1; req_rd = '0; sd_ack = 1'b0;
        step();

        // Fairness: all drives hold requests, expect 0,1,2,3,0
        req_rd = 4'hF;
        for (int t = 0; t < 5; t++) begin
            waits = 0; zeros = 0;
            while (!sd_rd && waits < 10) begin
                step();
                waits++;
                if (!busy) zeros++;
            end
            check("fair_grant", grant, 64'(t % 4));
            if (t > 0) begin
                check("fair_turnaround", waits, 3);
                check("fair_idle_gap", zeros, 1);
            end
            sd_ack = 1'b1;
            if (t == 4) req_rd = '0;
            step();
            check("fair_ack", req_ack, 4'b0001 << (t % 4));
            step(); step();
            sd_ack = 1'b0;
        end
        step(); step();

        // Cancel by drive 3 while drive 0 waits (last = 0)
        req_rd[3] = 1'b1;
        step();
        check("cx_grant", grant, 3);
        req_rd[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!sd_rd || req_ack != 0) bad++;
        end
        check("cx_hold", bad, 0);
        req_rd[3] = 1'b0;
        step();
        check("cx_rd_clr", sd_rd, 0);
        check("cx_idle", busy, 0);
        check("cx_ack", req_ack, 0);
        step();
        check("cx_next_grant", grant, 0);
        check("cx_next_rd", sd_rd, 1);
        sd_ack = 1'b1; req_rd = '0;
        step();
        sd_ack = 1'b0;
        step(); step();

        // Ack and cancel in the same cycle: ack wins (last = 0)
        req_rd[1] = 1'b1;
        step();
        req_rd[1] = 1'b0; sd_ack = 1'b1;
        step();
        check("ac_ack", req_ack, 4'b0010);
        check("ac_busy", busy, 1);
        sd_ack = 1'b0;
        step(); step();

        // Watchdog on drive 0
        req_rd[0] = 1'b1;
        step();
        check("to_grant", grant, 0);
`ifdef SDARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (timeout_err != 0 || !sd_rd) bad++;
        end
        check("to_wait", bad, 0);
        step();
        req_rd = '0;
        check("to_pulse", timeout_err, 4'b0001);
        check("to_rd_clr", sd_rd, 0);
        check("to_idle", busy, 0);
        step();
        check("to_pulse_end", timeout_err, 0);
`else
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (timeout_err != 0 || !sd_rd) bad++;
        end
        check("to_disabled", bad, 0);
        sd_ack = 1'b1; req_rd = '0;
        step();
        sd_ack = 1'b0;
        step(); step();
        check("to_idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
